// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM states, owner encoding and default timeout shared by the mem_arbiter slice.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select, fixed dmem priority or round robin under MEM_ARBITER_RR_EN.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   imem_req,
  input  logic   dmem_req,
`ifdef MEM_ARBITER_RR_EN
  input  owner_t last,
`endif
  output logic   any,
  output owner_t win
);
  assign any = imem_req | dmem_req;
`ifdef MEM_ARBITER_RR_EN
  always_comb win = (imem_req && dmem_req) ? ((last == OWN_DMEM) ? OWN_IMEM : OWN_DMEM)
                                           : (dmem_req ? OWN_DMEM : OWN_IMEM);
`else
  always_comb win = dmem_req ? OWN_DMEM : OWN_IMEM;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-outstanding fetch/data arbiter onto a shared memory; MEM_ARBITER_RR_EN enables round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_req,
  input  logic [31:0] i_imem_addr,
  output logic        o_imem_gnt,
  output logic        o_imem_valid,
  output logic [31:0] o_imem_rdata,
  input  logic        i_dmem_req,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_gnt,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_err,
  output logic        o_mem_req,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        state;
  owner_t        owner;
  owner_t        win;
  logic          any;
  logic          gnt;
  logic          dmem_win;
  logic          done;
  logic [31:0]   rsp;
  logic [CW-1:0] cnt;
`ifdef MEM_ARBITER_RR_EN
  owner_t        last;
`endif
  mem_arb_pick u_pick (
    .imem_req(i_imem_req),
    .dmem_req(i_dmem_req),
`ifdef MEM_ARBITER_RR_EN
    .last    (last),
`endif
    .any     (any),
    .win     (win)
  );
  // Grants are combinational but masked during reset so every output reads 0 while i_rst is high.
  assign gnt = state == IDLE && any && !i_rst;
  assign dmem_win = win == OWN_DMEM;
  assign o_imem_gnt = gnt && !dmem_win;
  assign o_dmem_gnt = gnt && dmem_win;
  assign done = i_mem_valid || cnt == CW'(TIMEOUT - 1);
  assign rsp = i_mem_valid ? i_mem_rdata : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      owner        <= OWN_IMEM;
      cnt          <= '0;
      o_imem_valid <= 1'b0;
      o_imem_rdata <= '0;
      o_dmem_valid <= 1'b0;
      o_dmem_rdata <= '0;
      o_err        <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wen    <= 1'b0;
      o_mem_wdata  <= '0;
      o_mem_mask   <= '0;
`ifdef MEM_ARBITER_RR_EN
      last         <= OWN_IMEM;
`endif
    end else begin
      o_imem_valid <= 1'b0;
      o_dmem_valid <= 1'b0;
      o_err        <= 1'b0;
      case (state)
        IDLE: if (gnt) begin
          state       <= ISSUE;
          owner       <= win;
          o_mem_req   <= 1'b1;
          o_mem_addr  <= (dmem_win ? i_dmem_addr : i_imem_addr) & 32'hFFFF_FFFC;
          o_mem_wen   <= dmem_win && i_dmem_wen;
          o_mem_wdata <= dmem_win ? i_dmem_wdata : '0;
          o_mem_mask  <= dmem_win ? i_dmem_mask : 4'hF;
`ifdef MEM_ARBITER_RR_EN
          last        <= win;
`endif
        end
        ISSUE: if (i_mem_ready) begin
          state     <= WAIT;
          o_mem_req <= 1'b0;
          cnt       <= '0;
        end
        WAIT: if (done) begin
          state <= IDLE;
          o_err <= !i_mem_valid;
          if (owner == OWN_DMEM) begin
            o_dmem_valid <= 1'b1;
            o_dmem_rdata <= rsp;
          end else begin
            o_imem_valid <= 1'b1;
            o_imem_rdata <= rsp;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, transaction-level random model and corner sequences for mem_arbiter (TIMEOUT=8).
module tb_mem_arbiter;
  localparam int T = 8;
  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_imem_req;
  logic [31:0] i_imem_addr;
  logic        o_imem_gnt;
  logic        o_imem_valid;
  logic [31:0] o_imem_rdata;
  logic        i_dmem_req;
  logic [31:0] i_dmem_addr;
  logic        i_dmem_wen;
  logic [31:0] i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic        o_dmem_gnt;
  logic        o_dmem_valid;
  logic [31:0] o_dmem_rdata;
  logic        o_err;
  logic        o_mem_req;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  mem_arbiter #(.TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr),
    .o_imem_gnt(o_imem_gnt), .o_imem_valid(o_imem_valid), .o_imem_rdata(o_imem_rdata),
    .i_dmem_req(i_dmem_req), .i_dmem_addr(i_dmem_addr), .i_dmem_wen(i_dmem_wen),
    .i_dmem_wdata(i_dmem_wdata), .i_dmem_mask(i_dmem_mask),
    .o_dmem_gnt(o_dmem_gnt), .o_dmem_valid(o_dmem_valid), .o_dmem_rdata(o_dmem_rdata),
    .o_err(o_err), .o_mem_req(o_mem_req), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .o_mem_mask(o_mem_mask), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        dwen;
    logic [3:0]  dmask;
    int          dr;
    int          k;
    logic [31:0] resp;
    logic        sp;
    logic        e_own;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_imem_req = 1'b0; i_imem_addr = '0;
    i_dmem_req = 1'b0; i_dmem_addr = '0; i_dmem_wen = 1'b0; i_dmem_wdata = '0; i_dmem_mask = '0;
    i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {21'b0, o_imem_gnt, o_imem_valid, o_dmem_gnt, o_dmem_valid, o_err,
                        o_mem_req, o_mem_wen, o_mem_mask}, 32'h0);
    chk({tag, "_irdata"}, o_imem_rdata, 32'h0);
    chk({tag, "_drdata"}, o_dmem_rdata, 32'h0);
    chk({tag, "_addr"}, o_mem_addr, 32'h0);
    chk({tag, "_wdata"}, o_mem_wdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // One complete transaction: grant, issue with ready after dr cycles, response k cycles into WAIT.
  task automatic run_vec(input vec_t v, input string tag);
    int lat = -1;
    @(negedge clk);
    i_imem_req = v.ireq; i_imem_addr = v.iaddr;
    i_dmem_req = v.dreq; i_dmem_addr = v.daddr; i_dmem_wen = v.dwen;
    i_dmem_wdata = v.dwdata; i_dmem_mask = v.dmask;
    i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = v.resp;
    #1;
    chk({tag, "_gnt"}, {30'b0, o_dmem_gnt, o_imem_gnt}, v.e_own ? 32'h2 : 32'h1);
    for (int t = 1; t < 40 && lat < 0; t++) begin
      @(negedge clk);
      i_imem_req = 1'b0; i_dmem_req = 1'b0;
      i_imem_addr = ~v.iaddr; i_dmem_addr = ~v.daddr; i_dmem_wdata = ~v.dwdata;
      i_dmem_mask = ~v.dmask; i_dmem_wen = ~v.dwen;
      i_mem_ready = t == v.dr + 1;
      i_mem_valid = t == v.dr + v.k + 2 || (v.sp && t <= v.dr + 1);
      i_mem_rdata = (t != v.dr + v.k + 2 && v.sp && t <= v.dr + 1) ? 32'hBAD0_BAD0 : v.resp;
      #1;
      if (t <= v.dr + 1) begin
        chk({tag, "_req"}, {31'b0, o_mem_req}, 32'h1);
        chk({tag, "_addr"}, o_mem_addr, v.e_addr);
        chk({tag, "_wen"}, {31'b0, o_mem_wen}, {31'b0, v.e_wen});
        chk({tag, "_wdata"}, o_mem_wdata, v.e_wdata);
        chk({tag, "_mask"}, {28'b0, o_mem_mask}, {28'b0, v.e_mask});
      end
      if (o_imem_valid || o_dmem_valid) lat = t;
    end
    chk({tag, "_lat"}, lat, v.e_lat);
    chk({tag, "_valid"}, {30'b0, o_dmem_valid, o_imem_valid}, v.e_own ? 32'h2 : 32'h1);
    chk({tag, "_err"}, {31'b0, o_err}, {31'b0, v.e_err});
    chk({tag, "_rdata"}, v.e_own ? o_dmem_rdata : o_imem_rdata, v.e_rdata);
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, "_pulse"}, {29'b0, o_dmem_valid, o_imem_valid, o_err}, 32'h0);
  endtask

  // Reference at transaction level: each grant fixes its ready cycle and response cycle up front,
  // from which the completion cycle, error flag and data follow arithmetically.
  task automatic random_phase(input int n);
    int g = 0, rdy = 0, rsp = -1, vc = -1, k;
    bit busy = 0, tmo = 0, ip = 0, dp = 0, own = 0, last_own = 0, exp_v, idle, win, gi, gd, on_bus;
    logic [31:0] ea = '0, ew = '0, resp = '0;
    logic ewen = 1'b0;
    logic [3:0] em = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; i_imem_addr = $urandom; end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; i_dmem_addr = $urandom; i_dmem_wen = 1'($urandom_range(0, 1));
        i_dmem_wdata = $urandom; i_dmem_mask = 4'($urandom_range(0, 15));
      end
      i_imem_req = ip; i_dmem_req = dp;
      i_mem_ready = busy && c == rdy;
      if (busy && c == rsp) begin
        i_mem_valid = 1'b1; i_mem_rdata = resp;
      end else begin
        i_mem_valid = (!busy || c <= rdy || c >= vc) && $urandom_range(0, 3) == 0;
        i_mem_rdata = $urandom;
      end
      #1;
      exp_v = busy && c == vc;
      idle = !busy || exp_v;
      chk("rnd_ivalid", {31'b0, o_imem_valid}, {31'b0, exp_v && !own});
      chk("rnd_dvalid", {31'b0, o_dmem_valid}, {31'b0, exp_v && own});
      chk("rnd_err", {31'b0, o_err}, {31'b0, exp_v && tmo});
      if (exp_v) chk("rnd_rdata", own ? o_dmem_rdata : o_imem_rdata, tmo ? 32'h0 : resp);
      gi = 0; gd = 0;
      if (idle && (ip || dp)) begin
`ifdef MEM_ARBITER_RR_EN
        win = (ip && dp) ? !last_own : dp;
`else
        win = dp;
`endif
        gi = !win; gd = win;
      end
      chk("rnd_gnt", {30'b0, o_dmem_gnt, o_imem_gnt}, {30'b0, gd, gi});
      on_bus = busy && c > g && c <= rdy;
      chk("rnd_req", {31'b0, o_mem_req}, {31'b0, on_bus});
      if (on_bus) begin
        chk("rnd_addr", o_mem_addr, ea);
        chk("rnd_wen", {31'b0, o_mem_wen}, {31'b0, ewen});
        chk("rnd_wdata", o_mem_wdata, ew);
        chk("rnd_mask", {28'b0, o_mem_mask}, {28'b0, em});
      end
      if (exp_v) busy = 0;
      if (gi || gd) begin
        busy = 1; own = gd; last_own = gd; g = c;
        ea = (gd ? i_dmem_addr : i_imem_addr) & ~32'h3;
        ewen = gd && i_dmem_wen;
        ew = gd ? i_dmem_wdata : 32'h0;
        em = gd ? i_dmem_mask : 4'hF;
        if (gd) dp = 0; else ip = 0;
        rdy = c + 1 + $urandom_range(0, 3);
        k = $urandom_range(0, 10);
        tmo = k >= T;
        resp = $urandom;
        rsp = tmo ? -1 : rdy + 1 + k;
        vc = tmo ? rdy + 1 + T : rdy + 2 + k;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t fv;
    bit got[4];
    int n;
    vt[0] = '{1'b1, 1'b0, 32'h100, 32'h5555_5555, 32'hFFFF_FFFF, 1'b1, 4'h5, 0, 0, 32'h1111_1111, 1'b0,
              1'b0, 32'h100, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h1111_1111};
    vt[1] = '{1'b0, 1'b1, 32'h0, 32'h2002, 32'h0, 1'b0, 4'hF, 0, 0, 32'h2468_ACE0, 1'b1,
              1'b1, 32'h2000, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h2468_ACE0};
    vt[2] = '{1'b0, 1'b1, 32'h0, 32'h3001, 32'hDEAD_BEEF, 1'b1, 4'h3, 4, 0, 32'h0, 1'b1,
              1'b1, 32'h3000, 1'b1, 32'hDEAD_BEEF, 4'h3, 7, 1'b0, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'h47, 32'h0, 32'h0, 1'b0, 4'h0, 1, 3, 32'hCAFE_F00D, 1'b0,
              1'b0, 32'h44, 1'b0, 32'h0, 4'hF, 7, 1'b0, 32'hCAFE_F00D};
    vt[4] = '{1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 1'b0, 4'h0, 0, 99, 32'hFFFF_FFFF, 1'b1,
              1'b0, 32'h200, 1'b0, 32'h0, 4'hF, 10, 1'b1, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 1'b0, 4'h0, 0, 0, 32'h0000_0204, 1'b0,
              1'b0, 32'h204, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h0000_0204};
    vt[6] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 4'h0, 0, 7, 32'h1234_5678, 1'b0,
              1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 4'hF, 10, 1'b0, 32'h1234_5678};
    vt[7] = '{1'b0, 1'b1, 32'h0, 32'h8, 32'h0101_0101, 1'b0, 4'h1, 2, 8, 32'h7777_7777, 1'b0,
              1'b1, 32'h8, 1'b0, 32'h0101_0101, 4'h1, 12, 1'b1, 32'h0};

    // Reset with both requesters active: everything, grants included, must read 0.
    i_rst = 1'b1;
    idle_inputs();
    i_imem_req = 1'b1; i_dmem_req = 1'b1; i_imem_addr = 32'h1234; i_dmem_addr = 32'h5678;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_zero("reset");
    i_rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Tie: dmem first, imem granted in the very cycle dmem's valid pulses.
    do_reset();
    @(negedge clk);
    i_imem_req = 1'b1; i_imem_addr = 32'h100;
    i_dmem_req = 1'b1; i_dmem_addr = 32'h2002; i_dmem_wen = 1'b0; i_dmem_mask = 4'hF;
    #1;
    chk("tie_gnt", {30'b0, o_dmem_gnt, o_imem_gnt}, 32'h2);
    @(negedge clk);
    i_dmem_req = 1'b0; i_mem_ready = 1'b1;
    #1;
    chk("tie_addr", o_mem_addr, 32'h2000);
    chk("tie_nognt_issue", {31'b0, o_imem_gnt}, 32'h0);
    @(negedge clk);
    i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'hA5A5_0001;
    #1;
    chk("tie_nognt_wait", {30'b0, o_imem_gnt, o_dmem_valid}, 32'h0);
    @(negedge clk);
    i_mem_valid = 1'b0;
    #1;
    chk("tie_dvalid", {31'b0, o_dmem_valid}, 32'h1);
    chk("tie_drdata", o_dmem_rdata, 32'hA5A5_0001);
    chk("tie_igrant", {31'b0, o_imem_gnt}, 32'h1);
    @(negedge clk);
    i_imem_req = 1'b0; i_mem_ready = 1'b1;
    #1;
    chk("tie_iaddr", o_mem_addr, 32'h100);
    chk("tie_ireq", {30'b0, o_mem_req, o_mem_wen}, 32'h2);
    @(negedge clk);
    i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'h0F0F_0F0F;
    @(negedge clk);
    i_mem_valid = 1'b0;
    #1;
    chk("tie_ivalid", {31'b0, o_imem_valid}, 32'h1);
    chk("tie_irdata", o_imem_rdata, 32'h0F0F_0F0F);

    // Both requesters held with an immediate memory: grant order reveals the policy.
    do_reset();
    @(negedge clk);
    i_imem_req = 1'b1; i_dmem_req = 1'b1; i_mem_ready = 1'b1; i_mem_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (o_dmem_gnt || o_imem_gnt) begin got[n] = o_dmem_gnt; n++; end
      @(negedge clk);
    end
    chk("hold_count", n, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_RR_EN
      chk($sformatf("hold_seq%0d", i), {31'b0, got[i]}, (i % 2 == 0) ? 32'h1 : 32'h0);
`else
      chk($sformatf("hold_seq%0d", i), {31'b0, got[i]}, 32'h1);
`endif
    end

    // Reset while waiting for the response: the transaction vanishes silently.
    do_reset();
    @(negedge clk);
    i_imem_req = 1'b1; i_imem_addr = 32'h400;
    #1;
    chk("rstw_gnt", {31'b0, o_imem_gnt}, 32'h1);
    @(negedge clk);
    i_imem_req = 1'b0; i_mem_ready = 1'b1;
    @(negedge clk);
    i_mem_ready = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    #1;
    chk_zero("rstw");
    i_rst = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'h6666_6666;
    @(negedge clk);
    i_mem_valid = 1'b0;
    #1;
    chk("rstw_req_low", {31'b0, o_mem_req}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("rstw_novalid", {30'b0, o_imem_valid, o_dmem_valid}, 32'h0);
    end
    fv = '{1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 1'b0, 4'h0, 0, 0, 32'h0000_0500, 1'b0,
           1'b0, 32'h500, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h0000_0500};
    run_vec(fv, "rstw_fetch");

    do_reset();
    random_phase(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 TIMEOUT, default 255: maximum WAIT cycles before a request is aborted with an error.
REQ-002 i_clk  in  1  global clock; all state changes on its rising edge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_imem_req  in  1  fetch request; held until granted.
REQ-005 i_imem_addr  in  32  fetch address.
REQ-006 o_imem_gnt  out  1  fetch request accepted this cycle.
REQ-007 o_imem_valid  out  1  one-cycle fetch completion pulse.
REQ-008 o_imem_rdata  out  32  fetched word; valid with o_imem_valid.
REQ-009 i_dmem_req  in  1  data request; held until granted.
REQ-010 i_dmem_addr  in  32  data byte address.
REQ-011 i_dmem_wen  in  1  1 = store, 0 = load.
REQ-012 i_dmem_wdata  in  32  store data, lane-aligned.
REQ-013 i_dmem_mask  in  4  byte-lane mask.
REQ-014 o_dmem_gnt  out  1  data request accepted this cycle.
REQ-015 o_dmem_valid  out  1  one-cycle data completion pulse, loads and stores.
REQ-016 o_dmem_rdata  out  32  load word; valid with o_dmem_valid.
REQ-017 o_err  out  1  timeout flag; qualifies the concurrent o_imem_valid or o_dmem_valid.
REQ-018 o_mem_req  out  1  request to the shared backing memory.
REQ-019 i_mem_ready  in  1  memory accepts the request this cycle.
REQ-020 o_mem_addr  out  32  word-aligned address: addr[31:2], 2'b00.
REQ-021 o_mem_wen  out  1  1 = write, 0 = read.
REQ-022 o_mem_wdata  out  32  write data.
REQ-023 o_mem_mask  out  4  byte-lane mask.
REQ-024 i_mem_valid  in  1  response or write acknowledge.
REQ-025 i_mem_rdata  in  32  read data; valid with i_mem_valid.

Function
REQ-026 The block SHALL implement an FSM with states IDLE, ISSUE and WAIT, and SHALL allow at most one outstanding transaction.
REQ-027 In IDLE with any request, the block SHALL combinationally assert the winner's gnt, latch addr/wen/wdata/mask/owner at that edge, and enter ISSUE.
REQ-028 Fetches SHALL be latched with wen=0, mask=4'b1111 and wdata=0.
REQ-029 In ISSUE the block SHALL hold o_mem_req=1 with the latched fields stable, and SHALL enter WAIT on the edge where i_mem_ready=1.
REQ-030 In WAIT on i_mem_valid the block SHALL register i_mem_rdata into the owner's rdata, pulse the owner's valid the next cycle, and enter IDLE.
REQ-031 The memory returns i_mem_valid no earlier than one cycle after ready; i_mem_valid outside WAIT SHALL be ignored.
REQ-032 The WAIT counter SHALL clear on entry to WAIT; when it reaches TIMEOUT without valid, the block SHALL pulse owner valid with o_err=1 and rdata=0, then enter IDLE.
REQ-033 Minimum latency SHALL be 3 cycles from gnt to valid, with ready and valid each arriving in their first possible cycle.
REQ-034 Default priority SHALL be fixed: dmem over imem on simultaneous requests.
REQ-035 No gnt SHALL be asserted outside IDLE; a new grant SHALL be possible in the same cycle that the previous valid pulses.

Reset
REQ-036 When i_rst is asserted the block SHALL enter IDLE with all outputs 0, including rdata, and the counter and RR pointer cleared.
REQ-037 Reset mid-transaction SHALL drop the transaction with no valid pulse, and SHALL leave o_mem_req low the cycle after reset.

Configuration
REQ-038 With MEM_ARBITER_RR_EN defined, ties SHALL go to the requester not granted last, and the pointer SHALL update on each gnt.
REQ-039 Without MEM_ARBITER_RR_EN defined, the fixed priority of REQ-034 SHALL apply and no pointer flop SHALL exist.

Structure
REQ-040 Package mem_arb_pkg SHALL hold the state enum, the owner encoding (OWN_IMEM, OWN_DMEM) and the default TIMEOUT.
REQ-041 Sub-module mem_arb_pick SHALL hold the combinational winner selection, fixed or RR.

Verification
REQ-042 Simultaneous imem@0x100 and dmem load@0x2002: dmem is granted first; o_mem_addr=0x2000; with ready and valid immediate, o_dmem_valid comes 3 cycles after gnt, then imem is granted.
REQ-043 dmem store 0xDEADBEEF with mask 4'b0011 and ready stalled 4 cycles: o_mem_req and its fields are held stable; o_dmem_valid=1 after the ack.
REQ-044 With TIMEOUT=8 and i_mem_valid never asserted: o_imem_valid=1, o_err=1 and rdata=0 after 8 WAIT cycles; the next request then proceeds normally.
REQ-045 i_rst pulsed during WAIT: no valid pulse, all outputs 0, and a subsequent fetch completes correctly.
REQ-046 With MEM_ARBITER_RR_EN defined and both requesters held continuously: grants alternate dmem, imem, dmem, imem; without the macro, dmem takes every grant.
